// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg: shared widths, grant select and wait-counter sizing for the RF write-port arbiter.
package rf_wport_arbiter_pkg;
    localparam int NB_DATA_DEF  = 32;
    localparam int NB_ADDR_DEF  = 5;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_DBG
    } gnt_e;

    function automatic int cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

    localparam int NB_CNT_DEF = cnt_width(MAX_WAIT_DEF);
endpackage

// File: rtl/rf_wport_arbiter_dbg_wr_buffer.sv
// dbg_wr_buffer: one-entry valid/ready holding register for debug register writes.
module dbg_wr_buffer
    import rf_wport_arbiter_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic [NB_ADDR-1:0] addr,
    input  logic [NB_DATA-1:0] data,
    input  logic               pop,
    output logic               ready,
    output logic               full,
    output logic [NB_ADDR-1:0] buf_addr,
    output logic [NB_DATA-1:0] buf_data
);
    assign ready = !full;

    // Push only happens while empty and pop only while full, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (valid && !full) begin
            full     <= 1'b1;
            buf_addr <= addr;
            buf_data <= data;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the RF write port between writeback (priority) and a buffered debug requester.
// Optional RFWR_R0_GUARD_EN: writes to register 0 are granted but suppressed on the port.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_ADDR  = NB_ADDR_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wb_regWrite,
    input  logic [NB_ADDR-1:0] i_wb_reg2write,
    input  logic [NB_DATA-1:0] i_wb_write_data,
    input  logic               i_dbg_valid,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    input  logic [NB_DATA-1:0] i_dbg_data,
    output logic               o_dbg_ready,
    output logic               o_wb_stall,
    output logic               o_rf_we,
    output logic [NB_ADDR-1:0] o_rf_addr,
    output logic [NB_DATA-1:0] o_rf_data
);
    localparam int NB_CNT = cnt_width(MAX_WAIT);
    localparam logic [NB_CNT-1:0] WAIT_MAX = NB_CNT'(MAX_WAIT);

    logic               buf_full;
    logic [NB_ADDR-1:0] buf_addr;
    logic [NB_DATA-1:0] buf_data;
    logic [NB_CNT-1:0]  wait_cnt;
    logic               wb_req;
    logic               forced;
    logic               we_next;
    gnt_e               gnt;

    dbg_wr_buffer #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR)
    ) u_buf (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .valid   (i_dbg_valid),
        .addr    (i_dbg_addr),
        .data    (i_dbg_data),
        .pop     (gnt == GNT_DBG),
        .ready   (o_dbg_ready),
        .full    (buf_full),
        .buf_addr(buf_addr),
        .buf_data(buf_data)
    );

`ifdef RFWR_R0_GUARD_EN
    // A writeback to r0 never competes for the port, so it can never be stalled.
    assign wb_req  = i_wb_regWrite && (i_wb_reg2write != '0);
    assign we_next = (gnt == GNT_WB) || (gnt == GNT_DBG && buf_addr != '0);
`else
    assign wb_req  = i_wb_regWrite;
    assign we_next = gnt != GNT_NONE;
`endif

    always_comb begin
        forced     = buf_full && (wait_cnt == WAIT_MAX);
        gnt        = (buf_full && (!wb_req || forced)) ? GNT_DBG :
                     wb_req                            ? GNT_WB  : GNT_NONE;
        o_wb_stall = wb_req && (gnt == GNT_DBG);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rf_we   <= 1'b0;
            o_rf_addr <= '0;
            o_rf_data <= '0;
        end else begin
            o_rf_we <= we_next;
            if (we_next) begin
                o_rf_addr <= (gnt == GNT_DBG) ? buf_addr : i_wb_reg2write;
                o_rf_data <= (gnt == GNT_DBG) ? buf_data : i_wb_write_data;
            end
        end
    end

    // Counts cycles a full buffer loses to writeback; saturates so the forced grant is sticky.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt <= '0;
        end else if (!buf_full || gnt == GNT_DBG) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: randomized + directed scoreboard bench for rf_wport_arbiter.
module tb_rf_wport_arbiter;
    localparam int MAX_WAIT = 4;
`ifdef RFWR_R0_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        dbg_valid = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data = '0;
    logic        dbg_ready;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit dbg_rand = 1'b0;

    wr_t  wb_q[$];
    wr_t  dbg_q[$];
    wr_t  pend[$];
    exp_t expq[$];
    int   waited = 0;
    logic [31:0] dut_rf [32];

    rf_wport_arbiter #(.NB_DATA(32), .NB_ADDR(5), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wb_regWrite  (wb_we),
        .i_wb_reg2write (wb_addr),
        .i_wb_write_data(wb_data),
        .i_dbg_valid    (dbg_valid),
        .i_dbg_addr     (dbg_addr),
        .i_dbg_data     (dbg_data),
        .o_dbg_ready    (dbg_ready),
        .o_wb_stall     (wb_stall),
        .o_rf_we        (rf_we),
        .o_rf_addr      (rf_addr),
        .o_rf_data      (rf_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every port write, and every cycle a write is due, is matched against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (rf_we) dut_rf[rf_addr] = rf_data;
            if (rf_we || (expq.size() > 0 && expq[0].cyc == cyc)) begin
                if (expq.size() == 0 || expq[0].cyc != cyc) begin
                    chk("spurious_write", {rf_addr, rf_data}, '0);
                end else begin
                    chk("port_we", rf_we, 1'b1);
                    chk("port_addr", rf_addr, expq[0].a);
                    chk("port_data", rf_data, expq[0].d);
                    void'(expq.pop_front());
                end
            end
        end
    end

    // One cycle: present the pipeline/debug heads, predict ready/stall and the port write.
    task automatic cycle();
        wr_t w;
        wr_t q;
        logic dv, rdy, wbr, dgo, stl;
        @(negedge clk);
        w  = (wb_q.size() > 0) ? wb_q[0] : '{1'b0, 5'd0, 32'd0};
        q  = (dbg_q.size() > 0) ? dbg_q[0] : '{1'b0, 5'd0, 32'd0};
        dv = (dbg_q.size() > 0) && (!dbg_rand || $urandom_range(3) != 0);
        wb_we = w.v; wb_addr = w.a; wb_data = w.d;
        dbg_valid = dv; dbg_addr = q.a; dbg_data = q.d;
        #1;
        rdy = pend.size() == 0;
        wbr = w.v && !(GUARD && w.a == 5'd0);
        dgo = !rdy && (!wbr || waited >= MAX_WAIT);
        stl = wbr && dgo;
        chk("dbg_ready", dbg_ready, rdy);
        chk("wb_stall", wb_stall, stl);
        if (dgo) begin
            if (!(GUARD && pend[0].a == 5'd0)) expq.push_back('{pend[0].a, pend[0].d, cyc + 1});
            void'(pend.pop_front());
            waited = 0;
        end else if (wbr) begin
            expq.push_back('{w.a, w.d, cyc + 1});
            if (!rdy && waited < MAX_WAIT) waited++;
        end
        if (rdy && dv) begin
            pend.push_back(q);
            void'(dbg_q.pop_front());
        end
        if (!stl && wb_q.size() > 0) void'(wb_q.pop_front());
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (wb_q.size() + dbg_q.size() + pend.size()) > 0; i++) cycle();
        chk("drain_left", wb_q.size() + dbg_q.size() + pend.size(), 0);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wb_we = 1'b0; dbg_valid = 1'b0;
        wb_q.delete(); dbg_q.delete(); pend.delete();
        waited = 0;
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_addr", rf_addr, 5'd0);
        chk("rst_rf_data", rf_data, 32'd0);
        chk("rst_dbg_ready", dbg_ready, 1'b1);
        chk("rst_wb_stall", wb_stall, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        foreach (dut_rf[i]) dut_rf[i] = '0;
        do_reset();
        // 1: single writeback
        wb_q.push_back('{1'b1, 5'd5, 32'h0000_00AA});
        drain();
        chk("t1_r5", dut_rf[5], 32'hAA);
        // 2: lone debug write
        dbg_q.push_back('{1'b1, 5'd7, 32'hDEAD_BEEF});
        drain();
        chk("t2_r7", dut_rf[7], 32'hDEAD_BEEF);
        // 3: writeback busy every cycle, buffered debug must be forced through
        for (int i = 1; i <= 8; i++) wb_q.push_back('{1'b1, 5'(i), 32'h100 + i});
        dbg_q.push_back('{1'b1, 5'd9, 32'h1234});
        drain();
        chk("t3_r8", dut_rf[8], 32'h108);
        chk("t3_r9", dut_rf[9], 32'h1234);
        // 4: same address, writeback first then debug
        wb_q.push_back('{1'b1, 5'd3, 32'h11});
        dbg_q.push_back('{1'b1, 5'd3, 32'h22});
        drain();
        chk("t4_r3_final", dut_rf[3], 32'h22);
        // 5: reset while a debug write waits
        for (int i = 1; i <= 8; i++) wb_q.push_back('{1'b1, 5'(i + 10), 32'h200 + i});
        dbg_q.push_back('{1'b1, 5'd30, 32'hBAD0});
        repeat (3) cycle();
        do_reset();
        drain();
        chk("t5_r30_untouched", dut_rf[30], 32'h0);
        // 6: register 0 from both sides
        dbg_q.push_back('{1'b1, 5'd0, 32'h5555});
        drain();
        wb_q.push_back('{1'b1, 5'd0, 32'h6666});
        drain();
        // Random traffic
        dbg_rand = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (wb_q.size() < 2)
                wb_q.push_back('{($urandom_range(99) < 65), 5'($urandom), $urandom});
            if (dbg_q.size() == 0 && $urandom_range(3) == 0)
                dbg_q.push_back('{1'b1, 5'($urandom), $urandom});
            if ($urandom_range(599) == 0) do_reset();
            else cycle();
        end
        drain();
        chk("scoreboard_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
Owns the single register-file write port and shares it between two requesters: the writeback stage and the debug unit. The writeback stage has priority. The debug unit makes write requests through a valid/ready handshake into a one-entry buffer. A starvation counter forces a debug grant by stalling the pipeline for one cycle. The block sits between the writeback stage outputs and the register-file write port.

Parameters:
NB_DATA, 32, register data width
NB_ADDR, 5, register address width
MAX_WAIT, 4, max cycles a buffered debug write waits while writeback holds the port (valid range 1..15)

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_wb_regWrite  in  1  writeback requests a register write this cycle
i_wb_reg2write  in  NB_ADDR  writeback destination register
i_wb_write_data  in  NB_DATA  writeback data
i_dbg_valid  in  1  debug write request valid
i_dbg_addr  in  NB_ADDR  debug destination register
i_dbg_data  in  NB_DATA  debug write data
o_dbg_ready  out  1  one-entry debug buffer is empty, so the request can be accepted
o_wb_stall  out  1  combinational; writeback is refused this cycle and must hold and retry
o_rf_we  out  1  register-file write enable (registered)
o_rf_addr  out  NB_ADDR  register-file write address (registered)
o_rf_data  out  NB_DATA  register-file write data (registered)

Behaviour:
- One clock (i_clk), asynchronous active-low reset (i_rst_n); all state is cleared while i_rst_n=0.
- Reset values:
  - o_rf_we=0, o_rf_addr=0, o_rf_data=0.
  - Buffer empty, so o_dbg_ready=1; wait_cnt=0; o_wb_stall=0.
- Handshake: debug transfer occurs on a clock edge where i_dbg_valid && o_dbg_ready. Addr and data are captured and the buffer becomes full.
- o_dbg_ready = !buf_full. A freed buffer reports ready the cycle after the grant, so there is no same-cycle refill. Peak debug throughput is 1 write per 2 cycles.
- Arbitration is evaluated each cycle, combinationally from current inputs and state:
  - WB_GRANT: i_wb_regWrite && !(buf_full && wait_cnt==MAX_WAIT). The writeback write is registered to the port.
  - DBG_GRANT: buf_full && (!i_wb_regWrite || wait_cnt==MAX_WAIT). The buffered write is registered to the port and the buffer is emptied.
  - NONE: o_rf_we goes to 0 on the next edge; addr/data hold their previous values.
- o_wb_stall = i_wb_regWrite && DBG_GRANT (forced case only). The pipeline freezes MEM/WB and re-presents the same write next cycle, which then wins because the buffer is empty.
- Latency: a grant in cycle N appears on o_rf_* after edge N+1; exactly one write per cycle.
- wait_cnt:
  - Cleared when the buffer is empty or on DBG_GRANT.
  - Otherwise increments each cycle the buffer is full and writeback wins.
  - Saturates at MAX_WAIT.
- Simultaneous debug accept and grant in the same cycle is impossible, since ready=0 while full.
- A debug request and a writeback request to the same address in the same cycle: writeback is written first. The debug value lands later and is the final value.
- Reset mid-operation: a pending buffered debug write is dropped. No partial write appears on the port.

Optional Feature:
RFWR_R0_GUARD_EN
- Defined: any request (writeback or debug) addressed to register 0 is treated as granted but suppressed. o_rf_we stays 0, the buffer is still emptied, and writeback is never stalled for it.
- Undefined: writes to register 0 pass to the port unchanged; the register file is responsible for ignoring them.

Decomposition:
- Shared package: NB_DATA/NB_ADDR defaults, grant-select enum (GNT_NONE, GNT_WB, GNT_DBG), MAX_WAIT default, counter width derived from MAX_WAIT.
- One natural sub-module: dbg_wr_buffer, the one-entry valid/ready holding register with full flag. Arbitration, counter and output registers stay in the top.

Test Plan:
1. Reset, then writeback writes r5=0x0000_00AA for one cycle → next cycle o_rf_we=1, o_rf_addr=5, o_rf_data=0xAA; o_wb_stall=0 throughout.
2. Pipeline idle, debug valid r7=0xDEAD_BEEF → accepted, o_dbg_ready=0 one cycle → next cycle granted, o_rf_we=1 addr 7; o_dbg_ready=1 the cycle after.
3. Writeback busy every cycle (r1..r8), debug r9=0x1234 buffered, MAX_WAIT=4 → 4 writeback writes, then o_wb_stall=1 for exactly one cycle, r9 written, the stalled writeback write is emitted next with no loss or duplication.
4. Writeback r3=0x11 and debug r3=0x22 in the same cycle → port writes 0x11 then 0x22; final r3=0x22.
5. Debug write buffered, i_rst_n pulsed low mid-wait → no debug write appears; o_dbg_ready=1, o_rf_we=0 after reset.
6. RFWR_R0_GUARD_EN defined, debug write to r0 then writeback to r0 → o_rf_we never asserts; o_dbg_ready returns to 1; o_wb_stall stays 0.
